bus_arbiter: RTL and testbench

- Shares the single BF memory/IO bus (opcode, 16-bit addr, 8-bit data) between NUM_REQ requesters, e.g. the BF core plus a program loader/debug port.
- Forwards one captured transaction at a time to the downstream bus sequencer (the io_in/io_out serializer) and returns its read value to the granted requester.
- Round-robin fair; the grant is held until the downstream completion.

---
 rtl/bus_arbiter_pkg.sv | 28 ++
 rtl/bus_arbiter_rr_pick.sv | 33 +++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: opcodes, arbiter states and bus widths.
// Imported by the arbiter, its round-robin picker and the bench.
package bus_arbiter_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [2:0] {
        BusNone  = 3'd0,
        BusRead  = 3'd1,
        BusWrite = 3'd2,
        BusIn    = 3'd3,
        BusOut   = 3'd4
    } BusOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } ArbState;

    typedef struct packed {
        BusOp                  op;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] val;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after start_i,
// wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] start_i,
    output logic            hit_o,
    output logic [IDXW-1:0] idx_o
);

    logic [IDXW:0] cand;

    // Walk N candidates from start_i; the wrap is an explicit compare
    // so that non-power-of-2 N never selects a missing requester.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, start_i} + (IDXW+1)'(k);
            if (cand > (IDXW+1)'(N-1)) begin
                cand = cand - (IDXW+1)'(N);
            end
            if (!hit_o && req_i[cand[IDXW-1:0]]) begin
                hit_o = 1'b1;
                idx_o = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the memory/IO bus between requesters.
// One captured transaction in flight; grant held until m_done.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  BusOp                  req_op   [NUM_REQ],
    input  logic [BUS_ADDR_W-1:0] req_addr [NUM_REQ],
    input  logic [BUS_DATA_W-1:0] req_val  [NUM_REQ],
    output logic [NUM_REQ-1:0]    rsp_done,
    output logic [BUS_DATA_W-1:0] rsp_val,
    output BusOp                  m_op,
    output logic [BUS_ADDR_W-1:0] m_addr,
    output logic [BUS_DATA_W-1:0] m_val_out,
    input  logic                  m_done,
    input  logic [BUS_DATA_W-1:0] m_val_in,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  busy,
    output logic                  protocol_err
);

    ArbState               state_q, state_d;
    logic [IDXW-1:0]       rr_q, rr_d;
    logic [IDXW-1:0]       grant_q, grant_d;
    bus_req_t              cap_q, cap_d;
    logic [BUS_DATA_W-1:0] rsp_val_q, rsp_val_d;
    logic                  perr_q, perr_d;

    logic [NUM_REQ-1:0]    req_vec;
    logic                  pick_hit;
    logic [IDXW-1:0]       pick_idx;

    // Any opcode other than BusNone is a pending request.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = (req_op[i] != BusNone);
        end
    end

    rr_pick #(
        .N    (NUM_REQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (req_vec),
        .start_i (rr_q),
        .hit_o   (pick_hit),
        .idx_o   (pick_idx)
    );

    // Next-state logic; everything holds while enable is low.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        cap_d     = cap_q;
        rsp_val_d = rsp_val_q;
        perr_d    = perr_q;
        if (enable) begin
            if (m_done && (state_q != BUSY)) begin
                perr_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (pick_hit) begin
                        grant_d    = pick_idx;
                        cap_d.op   = req_op[pick_idx];
                        cap_d.addr = req_addr[pick_idx];
                        cap_d.val  = req_val[pick_idx];
                        state_d    = BUSY;
                    end
                end
                BUSY: begin
                    if (m_done) begin
                        rsp_val_d = m_val_in;
                        state_d   = RESP;
                    end
                end
                RESP: begin
                    if (grant_q == IDXW'(NUM_REQ-1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_q + 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and capture registers; reset aborts any transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            cap_q     <= '{op: BusNone, addr: '0, val: '0};
            rsp_val_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            cap_q     <= cap_d;
            rsp_val_q <= rsp_val_d;
            perr_q    <= perr_d;
        end
    end

    // Completion pulse is suppressed while stalled so it fires once.
    always_comb begin
        rsp_done = '0;
        if ((state_q == RESP) && enable) begin
            rsp_done[grant_q] = 1'b1;
        end
    end

    assign m_op         = (state_q == BUSY) ? cap_q.op : BusNone;
    assign m_addr       = cap_q.addr;
    assign m_val_out    = cap_q.val;
    assign rsp_val      = rsp_val_q;
    assign grant_idx    = grant_q;
    assign busy         = (state_q != IDLE);
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two requesters.
// Hand-computed expectations, one checking task.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        enable;
    BusOp        req_op   [2];
    logic [15:0] req_addr [2];
    logic [7:0]  req_val  [2];
    logic [1:0]  rsp_done;
    logic [7:0]  rsp_val;
    BusOp        m_op;
    logic [15:0] m_addr;
    logic [7:0]  m_val_out;
    logic        m_done;
    logic [7:0]  m_val_in;
    logic [0:0]  grant_idx;
    logic        busy;
    logic        protocol_err;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.NUM_REQ(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_val      (req_val),
        .rsp_done     (rsp_done),
        .rsp_val      (rsp_val),
        .m_op         (m_op),
        .m_addr       (m_addr),
        .m_val_out    (m_val_out),
        .m_done       (m_done),
        .m_val_in     (m_val_in),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // One contention transaction: ack 3 cycles after m_op appears.
    task automatic txn(input int idx, input logic [15:0] a,
                       input logic [7:0] v);
        step();
        chk("c_grant", grant_idx, idx);
        chk("c_op", m_op, BusRead);
        chk("c_addr", m_addr, a);
        step();
        step();
        chk("c_hold", m_op, BusRead);
        chk("c_nodone", rsp_done, 0);
        m_done = 1'b1;
        m_val_in = v;
        step();
        m_done = 1'b0;
        chk("c_done", rsp_done, (idx == 0) ? 2'b01 : 2'b10);
        chk("c_rval", rsp_val, v);
        step();
        chk("c_bubble", m_op, BusNone);
        chk("c_idle", busy, 0);
    endtask

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b1;
        m_done   = 1'b0;
        m_val_in = 8'h00;
        for (int i = 0; i < 2; i++) begin
            req_op[i]   = BusNone;
            req_addr[i] = 16'h0;
            req_val[i]  = 8'h0;
        end
        #2;
        do_reset();

        chk("rst_mop", m_op, BusNone);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_done", rsp_done, 0);
        chk("rst_rval", rsp_val, 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_maddr", m_addr, 0);

        // Single request
        req_op[0]   = BusRead;
        req_addr[0] = 16'h1234;
        chk("s_lat0", m_op, BusNone);
        step();
        chk("s_op", m_op, BusRead);
        chk("s_addr", m_addr, 16'h1234);
        chk("s_busy", busy, 1);
        m_done   = 1'b1;
        m_val_in = 8'hA5;
        step();
        m_done = 1'b0;
        chk("s_done", rsp_done, 2'b01);
        chk("s_rval", rsp_val, 8'hA5);
        chk("s_respop", m_op, BusNone);
        chk("s_respbusy", busy, 1);
        req_op[0] = BusNone;
        step();
        chk("s_busy_lo", busy, 0);
        chk("s_done_lo", rsp_done, 0);
        chk("s_rval_hold", rsp_val, 8'hA5);

        // Contention from reset
        do_reset();
        req_op[0]   = BusRead;
        req_addr[0] = 16'h1000;
        req_op[1]   = BusRead;
        req_addr[1] = 16'h2000;
        for (int t = 0; t < 4; t++) begin
            txn(t % 2, (t % 2 == 0) ? 16'h1000 : 16'h2000,
                8'(8'h10 + t));
        end

        // Request change mid-flight (rr now 0, only requester 1)
        req_op[0]   = BusNone;
        req_op[1]   = BusWrite;
        req_addr[1] = 16'h00FF;
        req_val[1]  = 8'h3C;
        step();
        chk("m_grant", grant_idx, 1);
        chk("m_op", m_op, BusWrite);
        chk("m_addr", m_addr, 16'h00FF);
        chk("m_wval", m_val_out, 8'h3C);
        req_addr[1] = 16'hBEEF;
        req_val[1]  = 8'h00;
        req_op[1]   = BusNone;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("m_addr_hold", m_addr, 16'h00FF);
            chk("m_op_hold", m_op, BusWrite);
        end
        chk("m_wval_hold", m_val_out, 8'h3C);
        m_done   = 1'b1;
        m_val_in = 8'h77;
        step();
        m_done = 1'b0;
        chk("m_done", rsp_done, 2'b10);
        chk("m_rval", rsp_val, 8'h77);
        step();

        // Stall while BUSY and while in RESP
        req_op[0]   = BusRead;
        req_addr[0] = 16'h4242;
        step();
        chk("st_grant", grant_idx, 0);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("st_op", m_op, BusRead);
            chk("st_addr", m_addr, 16'h4242);
            chk("st_busy", busy, 1);
            chk("st_done", rsp_done, 0);
        end
        enable   = 1'b1;
        m_done   = 1'b1;
        m_val_in = 8'h5A;
        step();
        m_done = 1'b0;
        enable = 1'b0;
        #1;
        chk("st_resp_gated", rsp_done, 0);
        step();
        chk("st_resp_hold", busy, 1);
        chk("st_resp_gated2", rsp_done, 0);
        enable = 1'b1;
        #1;
        chk("st_resp_done", rsp_done, 2'b01);
        chk("st_rval", rsp_val, 8'h5A);
        req_op[0] = BusNone;
        step();
        chk("st_idle", busy, 0);

        // Async reset mid-transaction (rr now 1)
        req_op[1]   = BusWrite;
        req_addr[1] = 16'h0ABC;
        step();
        chk("ar_grant", grant_idx, 1);
        chk("ar_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_mop", m_op, BusNone);
        chk("ar_busy0", busy, 0);
        chk("ar_done", rsp_done, 0);
        chk("ar_grant0", grant_idx, 0);
        step();
        #3;
        reset_n = 1'b1;
        req_op[0]   = BusRead;
        req_addr[0] = 16'h0111;
        req_op[1]   = BusRead;
        req_addr[1] = 16'h0222;
        step();
        chk("ar_first", grant_idx, 0);
        chk("ar_faddr", m_addr, 16'h0111);
        m_done   = 1'b1;
        m_val_in = 8'h99;
        step();
        m_done = 1'b0;
        chk("ar_done2", rsp_done, 2'b01);
        req_op[0] = BusNone;
        req_op[1] = BusNone;
        step();

        // Spurious m_done in IDLE
        chk("sp_perr0", protocol_err, 0);
        m_done   = 1'b1;
        m_val_in = 8'hEE;
        step();
        m_done = 1'b0;
        chk("sp_perr", protocol_err, 1);
        chk("sp_done", rsp_done, 0);
        chk("sp_rval", rsp_val, 8'h99);
        chk("sp_busy", busy, 0);
        step();
        step();
        chk("sp_sticky", protocol_err, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
